// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives a 1-cycle-latency ROM and feeds
// decode through a 2-entry skid buffer with redirect/flush support.

module fetch_controller_checker (
  input logic clk_i,
  input logic rst_i,
  input logic capture_i,
  input logic full_i
);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(capture_i && full_i));

endmodule

module fetch_controller #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fetch_en_i,
  input  logic                  redirect_i,
  input  logic [31:0]           redirect_pc_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_data_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [31:0]           instr_pc_o
);

  logic [31:0]           pc_r;
  logic [31:0]           pend_pc_r;
  logic                  pending_r;
  logic                  head_valid_r;
  logic                  tail_valid_r;
  logic [DATA_WIDTH-1:0] head_data_r;
  logic [DATA_WIDTH-1:0] tail_data_r;
  logic [31:0]           head_pc_r;
  logic [31:0]           tail_pc_r;

  logic                  pop_s;
  logic                  issue_s;
  logic                  capture_s;
  logic [1:0]            count_s;
  logic [2:0]            occ_s;
  logic                  unused_s;

  logic                  sh_head_valid_s;
  logic                  sh_tail_valid_s;
  logic [DATA_WIDTH-1:0] sh_head_data_s;
  logic [31:0]           sh_head_pc_s;

  logic                  head_valid_nxt_s;
  logic                  tail_valid_nxt_s;
  logic [DATA_WIDTH-1:0] head_data_nxt_s;
  logic [DATA_WIDTH-1:0] tail_data_nxt_s;
  logic [31:0]           head_pc_nxt_s;
  logic [31:0]           tail_pc_nxt_s;

  assign unused_s  = ^redirect_pc_i[1:0];
  assign count_s   = {1'b0, head_valid_r} + {1'b0, tail_valid_r};
  assign pop_s     = head_valid_r & instr_ready_i;
  // Occupancy one cycle ahead: only issue if the returning word is sure to find a free slot.
  assign occ_s     = {1'b0, count_s} + {2'b00, pending_r} - {2'b00, pop_s};
  assign issue_s   = fetch_en_i & ~redirect_i & (occ_s < 3'd2);
  assign capture_s = pending_r & ~redirect_i;

  assign imem_addr_o   = pc_r[ADDR_WIDTH+1:2];
  assign instr_valid_o = head_valid_r;
  assign instr_o       = head_data_r;
  assign instr_pc_o    = head_pc_r;

  // Buffer contents after this cycle's pop (tail advances into head).
  always_comb begin
    sh_head_valid_s = head_valid_r;
    sh_tail_valid_s = tail_valid_r;
    sh_head_data_s  = head_data_r;
    sh_head_pc_s    = head_pc_r;
    if (pop_s) begin
      sh_head_valid_s = tail_valid_r;
      sh_tail_valid_s = 1'b0;
      sh_head_data_s  = tail_data_r;
      sh_head_pc_s    = tail_pc_r;
    end else begin
      sh_head_valid_s = head_valid_r;
      sh_tail_valid_s = tail_valid_r;
    end
  end

  // Buffer next state: redirect flush, else capture into the first free slot.
  always_comb begin
    head_valid_nxt_s = sh_head_valid_s;
    tail_valid_nxt_s = sh_tail_valid_s;
    head_data_nxt_s  = sh_head_data_s;
    head_pc_nxt_s    = sh_head_pc_s;
    tail_data_nxt_s  = tail_data_r;
    tail_pc_nxt_s    = tail_pc_r;
    if (redirect_i) begin
      head_valid_nxt_s = 1'b0;
      tail_valid_nxt_s = 1'b0;
    end else if (capture_s && !sh_head_valid_s) begin
      head_valid_nxt_s = 1'b1;
      head_data_nxt_s  = imem_data_i;
      head_pc_nxt_s    = pend_pc_r;
    end else if (capture_s) begin
      tail_valid_nxt_s = 1'b1;
      tail_data_nxt_s  = imem_data_i;
      tail_pc_nxt_s    = pend_pc_r;
    end else begin
      head_valid_nxt_s = sh_head_valid_s;
      tail_valid_nxt_s = sh_tail_valid_s;
    end
  end

  // Program counter and in-flight read tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_r      <= {RESET_PC[31:2], 2'b00};
      pend_pc_r <= 32'd0;
      pending_r <= 1'b0;
    end else if (redirect_i) begin
      pc_r      <= {redirect_pc_i[31:2], 2'b00};
      pending_r <= 1'b0;
    end else if (issue_s) begin
      pc_r      <= pc_r + 32'd4;
      pend_pc_r <= pc_r;
      pending_r <= 1'b1;
    end else begin
      pending_r <= 1'b0;
    end
  end

  // Skid buffer registers; head entry drives the decode outputs directly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_valid_r <= 1'b0;
      tail_valid_r <= 1'b0;
      head_data_r  <= '0;
      tail_data_r  <= '0;
      head_pc_r    <= 32'd0;
      tail_pc_r    <= 32'd0;
    end else begin
      head_valid_r <= head_valid_nxt_s;
      tail_valid_r <= tail_valid_nxt_s;
      head_data_r  <= head_data_nxt_s;
      tail_data_r  <= tail_data_nxt_s;
      head_pc_r    <= head_pc_nxt_s;
      tail_pc_r    <= tail_pc_nxt_s;
    end
  end

  fetch_controller_checker u_checker (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .capture_i (capture_s),
    .full_i    (count_s == 2'd2)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: streaming, stall, redirect, wrap,
// fetch disable and asynchronous reset, against a word-index ROM model.

module tb_fetch_controller;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_en = 1'b1;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
  logic          ready = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [31:0]   instr_pc;

  int check_cnt = 0;
  int pass_cnt  = 0;

  fetch_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .fetch_en_i    (fetch_en),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_addr_o   (imem_addr),
    .imem_data_i   (imem_data),
    .instr_valid_o (instr_valid),
    .instr_ready_i (ready),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc)
  );

  always #5 clk = ~clk;

  // ROM model: word n holds A000_0000 | n, one cycle of read latency.
  always_ff @(posedge clk) imem_data <= 32'hA000_0000 | {24'd0, imem_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic expect_head(input string tag, input logic [31:0] d, input logic [31:0] p);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_instr"}, instr, d);
    check({tag, "_pc"}, instr_pc, p);
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
  endtask

  task automatic expect_addr(input string tag, input logic [31:0] a);
    check({tag, "_addr"}, {24'd0, imem_addr}, a);
  endtask

  initial begin
    // Reset state and streaming latency/throughput
    cyc();
    expect_empty("rst");
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    expect_addr("rst", 32'd0);
    rst = 1'b0;
    cyc();
    expect_empty("lat_e1");
    expect_addr("lat_e1", 32'd1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      expect_head($sformatf("stream%0d", k), 32'hA000_0000 | k, 4 * k);
    end

    // Stall: head holds, issue stops at two buffered plus none in flight
    rst = 1'b1; ready = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      expect_head($sformatf("stall%0d", i), 32'hA000_0000, 32'd0);
      expect_addr($sformatf("stall%0d", i), 32'd2);
    end
    ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      cyc();
      expect_head($sformatf("drain%0d", k), 32'hA000_0000 | k, 4 * k);
    end

    // Redirect while the buffer is full
    rst = 1'b1; ready = 1'b0;
    cyc();
    rst = 1'b0;
    cyc(); cyc(); cyc();
    redirect = 1'b1; redirect_pc = 32'h0000_0043;
    cyc();
    redirect = 1'b0; ready = 1'b1;
    expect_empty("rdfull_t1");
    expect_addr("rdfull_t1", 32'h10);
    cyc();
    expect_empty("rdfull_t2");
    cyc();
    expect_head("rdfull_t3", 32'hA000_0010, 32'h40);
    cyc();
    expect_head("rdfull_t4", 32'hA000_0011, 32'h44);

    // Redirect in the same cycle as a pop, then back-to-back redirects
    rst = 1'b1; ready = 1'b1;
    cyc();
    rst = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    expect_head("rdpop_t0", 32'hA000_0002, 32'd8);
    redirect = 1'b1; redirect_pc = 32'h0000_0080;
    cyc();
    redirect = 1'b0;
    expect_empty("rdpop_t1");
    cyc();
    expect_empty("rdpop_t2");
    cyc();
    expect_head("rdpop_t3", 32'hA000_0020, 32'h80);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    cyc();
    redirect_pc = 32'h0000_0200;
    cyc();
    redirect = 1'b0;
    expect_empty("b2b_t1");
    cyc();
    expect_empty("b2b_t2");
    cyc();
    expect_head("b2b_t3", 32'hA000_0080, 32'h200);

    // ROM address wrap and 32-bit PC wrap
    redirect = 1'b1; redirect_pc = 32'h0000_03FC;
    cyc();
    redirect = 1'b0;
    expect_addr("wrap_t1", 32'hFF);
    cyc();
    expect_addr("wrap_t2", 32'h00);
    cyc();
    expect_head("wrap_a", 32'hA000_00FF, 32'h3FC);
    cyc();
    expect_head("wrap_b", 32'hA000_0000, 32'h400);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    cyc();
    redirect = 1'b0;
    cyc(); cyc();
    expect_head("pcwrap_a", 32'hA000_00FF, 32'hFFFF_FFFC);
    cyc();
    expect_head("pcwrap_b", 32'hA000_0000, 32'h0);

    // fetch_en=0: in-flight captured, buffer drains, resume at held PC
    rst = 1'b1; ready = 1'b1; fetch_en = 1'b1;
    cyc();
    rst = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    expect_head("fen_k2", 32'hA000_0002, 32'd8);
    fetch_en = 1'b0; ready = 1'b0;
    cyc();
    expect_head("fen_hold", 32'hA000_0002, 32'd8);
    expect_addr("fen_hold", 32'd4);
    ready = 1'b1;
    cyc();
    expect_head("fen_drain", 32'hA000_0003, 32'd12);
    cyc();
    expect_empty("fen_empty");
    expect_addr("fen_empty", 32'd4);
    fetch_en = 1'b1;
    cyc();
    expect_empty("fen_re1");
    cyc();
    expect_head("fen_resume", 32'hA000_0004, 32'd16);

    // Asynchronous reset mid-cycle clears outputs before the next edge
    #2;
    rst = 1'b1;
    #1;
    expect_empty("arst");
    check("arst_instr", instr, 32'd0);
    check("arst_pc", instr_pc, 32'd0);
    expect_addr("arst", 32'd0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    expect_empty("arst_e1");
    cyc();
    expect_head("arst_first", 32'hA000_0000, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Instruction-fetch sequencer that owns the program counter and drives the synchronous instruction ROM.
- The ROM has a 1-cycle registered read latency and no enable; it reads every cycle.
- Presents fetched instructions to decode over a valid/ready handshake, with a 2-entry skid buffer and branch/jump redirect with flush.
- Sits between the instruction ROM and the decode stage of the core.

Parameters:
- ADDR_WIDTH, 8, ROM word-address width; ROM holds 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, byte PC loaded on reset.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- fetch_en_i  in  1  1 = new ROM reads may be issued; 0 = issuing frozen, buffer still drains.
- redirect_i  in  1  one-cycle pulse: discard all fetched or in-flight work and restart at redirect_pc_i.
- redirect_pc_i  in  32  byte target PC; bits [1:0] ignored (treated as 0).
- imem_addr_o  out  ADDR_WIDTH  ROM word address = pc_q[ADDR_WIDTH+1:2].
- imem_data_i  in  DATA_WIDTH  ROM read data, valid the cycle after the address that produced it.
- instr_valid_o  out  1  buffer head holds a valid instruction.
- instr_ready_i  in  1  decode accepts the head when valid & ready.
- instr_o  out  DATA_WIDTH  head instruction.
- instr_pc_o  out  32  byte PC of head instruction.

Behaviour:
- Reset while rst_i=1:
  - pc_q=RESET_PC with bits [1:0]=0; pending=0; buffer count=0.
  - instr_valid_o=0; instr_o=0; instr_pc_o=0.
  - imem_addr_o = RESET_PC word index.
  - Reset asserted mid-operation clears everything immediately, including any in-flight read.
- Issue:
  - pop = instr_valid_o & instr_ready_i.
  - issue = fetch_en_i & ~redirect_i & (count + pending - pop < 2).
  - On issue: pending<=1; pend_pc<=pc_q; pc_q<=pc_q+4.
  - With no issue: pending<=0 and pc_q holds. The ROM address held stable is harmless because its data is not captured.
- Capture: when pending=1 and no redirect this cycle, {imem_data_i, pend_pc} is written into the buffer tail.
  - The issue rule guarantees the buffer is never full at capture; an overflow would be a design bug (assertion).
- Buffer:
  - 2-entry FIFO; head drives instr_o / instr_pc_o, which are registered outputs.
  - Push and pop in the same cycle are both honoured, and count is unchanged.
  - Head output stays stable while valid & ~ready.
- Redirect at cycle t:
  - Any pop in cycle t completes.
  - All remaining buffer entries are flushed and the in-flight read from cycle t-1 is discarded: pending<=0, count<=0.
  - pc_q <= {redirect_pc_i[31:2], 2'b00}.
  - instr_valid_o=0 from t+1.
  - New PC issues in t+1, is captured at end of t+2, and instr_valid_o=1 in t+3.
  - Back-to-back redirects: the latest one wins.
- Latency and throughput:
  - The first edge after reset release issues RESET_PC; the second captures it; instr_valid_o rises after the second edge.
  - With ready=1 and fetch_en=1, sustained throughput is 1 instruction/cycle with consecutive PCs.
- Wrap-around:
  - pc_q increments modulo 2**32.
  - imem_addr_o wraps modulo 2**ADDR_WIDTH words; instr_pc_o reports the full unwrapped 32-bit PC.
- fetch_en_i=0: in-flight read still captured; buffer drains normally; no new issue. On re-enable, fetch resumes at pc_q.

Test Plan:
- ROM model word n = 32'hA000_0000|n; reset release with ready=1, fetch_en=1 -> valid after 2nd edge; instr/pc sequence (A0000000,0),(A0000001,4),(A0000002,8)... one per cycle, no gaps.
- Stall: ready=0 for 5 cycles after first valid -> head holds (A0000000,0); no more than 2 entries buffered, imem_addr_o frozen at 2; on ready=1, pcs 0,4,8,12 in order with no loss or duplicate.
- Redirect at cycle t to 32'h0000_0043 while buffer is full -> valid=0 at t+1,t+2; at t+3 instr=A0000010, pc=0x40; stale pcs never appear.
- Redirect coinciding with a pop -> popped instruction counted once; next valid is the redirect target only.
- Wrap: redirect to 0x3FC (ADDR_WIDTH=8) -> pcs 0x3FC,0x400 with instr A00000FF,A0000000.
- fetch_en=0 then rst_i asserted mid-stream asynchronously -> outputs and valid clear immediately, before the next edge; after release, fetch restarts at RESET_PC.
